// File: rtl/rv32i_types_pkg.sv
// Shared types for the memory-side blocks: arbiter FSM states and an index-width helper.
// Pure declarations; no logic, latency or flow control of its own.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational winner pick: first requester at or after ptr, wrapping modulo N.
// Zero latency; no flow control, the caller decides when to consume the result.
module rr_priority_pick
    import rv32i_types::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int   cand;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            // ptr is always below N, so one subtraction completes the wrap
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[IW'(cand)]) begin
                found              = 1'b1;
                grant[IW'(cand)]   = 1'b1;
                idx                = IW'(cand);
            end
        end
        any = found;
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel cache-line arbiter to one L2 port; req->strobe 1 cycle, mem_resp->ch_resp 1 cycle, >=3 cycles/txn.
// Requesters hold levels until ch_resp; L2 stalls by withholding mem_resp. MEM_ARB_FIXED_PRIO_EN: fixed priority, ch0 highest.
module mem_arbiter_rr
    import rv32i_types::*;
#(
    parameter int NUM_CH = 2,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CH-1:0]          ch_read,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
    output logic [LINE_W-1:0]          ch_rdata,
    output logic [NUM_CH-1:0]          ch_resp,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [LINE_W-1:0]          mem_wdata,
    input  logic [LINE_W-1:0]          mem_rdata,
    input  logic                       mem_resp
);

    localparam int IW = idx_w(NUM_CH);

    arb_state_t        state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     grant;
    logic [IW-1:0]     ptr_after;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_wdata;

    assign req = ch_read | ch_write;

    rr_priority_pick #(.N(NUM_CH)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // One-hot AND-OR mux; a channel asserting both read and write is a write
    always_comb begin
        sel_write = |(pick_oh & ch_write);
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick_oh[i]) begin
                sel_addr  = sel_addr  | ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | ch_wdata[i*LINE_W +: LINE_W];
            end
        end
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Pointer stays at zero so the picker degenerates to lowest-index-first
    assign ptr_after = rr_ptr;
`else
    assign ptr_after = (grant == IW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            ch_resp   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ch_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ch_resp <= '0;
                    if (pick_any) begin
                        grant     <= pick_idx;
                        mem_read  <= ~sel_write;
                        mem_write <= sel_write;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        if (mem_read) begin
                            ch_rdata <= mem_rdata;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        ch_resp   <= NUM_CH'(1) << grant;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // Requests are not sampled here, so a just-served channel can drop cleanly
                    ch_resp <= '0;
                    rr_ptr  <= ptr_after;
                    state   <= IDLE;
                end
                default: begin
                    ch_resp   <= '0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Randomized bench for mem_arbiter_rr against a transaction-level model of pending requests.
module tb_mem_arbiter_rr;

    localparam int NUM_CH = 4;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [NUM_CH-1:0]        ch_read = '0;
    logic [NUM_CH-1:0]        ch_write = '0;
    logic [NUM_CH*ADDR_W-1:0] ch_addr = '0;
    logic [NUM_CH*LINE_W-1:0] ch_wdata = '0;
    logic [LINE_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_resp;
    logic                     mem_read;
    logic                     mem_write;
    logic [ADDR_W-1:0]        mem_addr;
    logic [LINE_W-1:0]        mem_wdata;
    logic [LINE_W-1:0]        mem_rdata = '0;
    logic                     mem_resp = 1'b0;

    mem_arbiter_rr #(.NUM_CH(NUM_CH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ch_read   (ch_read),
        .ch_write  (ch_write),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_rdata  (ch_rdata),
        .ch_resp   (ch_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: outstanding request per channel plus arbitration pointer
    bit                pend_vld  [NUM_CH];
    bit                pend_wr   [NUM_CH];
    bit                pend_both [NUM_CH];
    logic [ADDR_W-1:0] pend_addr [NUM_CH];
    logic [LINE_W-1:0] pend_wdata[NUM_CH];
    int                ptr = 0;
    logic [LINE_W-1:0] exp_rdata = '0;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic apply_reqs();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_read[i]  = pend_vld[i] && (!pend_wr[i] || pend_both[i]);
            ch_write[i] = pend_vld[i] && pend_wr[i];
            ch_addr[i*ADDR_W +: ADDR_W]  = pend_addr[i];
            ch_wdata[i*LINE_W +: LINE_W] = pend_wdata[i];
        end
    endtask

    task automatic set_req(input int i, input bit wr, input bit both,
                           input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        pend_vld[i] = 1'b1; pend_wr[i] = wr; pend_both[i] = both;
        pend_addr[i] = a;   pend_wdata[i] = d;
    endtask

    function automatic int expected_winner();
        int c;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            c = k;
`else
            c = (ptr + k) % NUM_CH;
`endif
            if (pend_vld[c]) return c;
        end
        return -1;
    endfunction

    // Requests must already be applied in an IDLE cycle at posedge+1
    task automatic serve(input int lat, input bit drop_mid, input logic [LINE_W-1:0] rdat, output int won);
        int  w;
        int  waited;
        bit  seen;
        logic [NUM_CH-1:0] oh;
        w = expected_winner();
        waited = 0; seen = 0; won = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin waited = c; seen = 1; break; end
        end
        chk("strobe_latency", waited, 2);
        if (!seen || w < 0) return;
        chk("mem_write", mem_write, pend_wr[w]);
        chk("mem_read", mem_read, !pend_wr[w]);
        chk("mem_addr", mem_addr, pend_addr[w]);
        if (pend_wr[w]) chk("mem_wdata", mem_wdata, pend_wdata[w]);
        for (int j = 0; j <= lat; j++) begin
            @(posedge clk); #1;
            if (j == 0 && drop_mid) begin pend_vld[w] = 1'b0; apply_reqs(); end
            if (j == lat) begin mem_resp = 1'b1; mem_rdata = rdat; end
            @(negedge clk);
            chk("busy_no_resp", ch_resp, '0);
            chk("busy_addr_hold", mem_addr, pend_addr[w]);
            chk("busy_strobe_hold", {mem_read, mem_write}, pend_wr[w] ? 2'b01 : 2'b10);
        end
        @(posedge clk); #1;
        mem_resp = 1'b0; mem_rdata = rand_line();
        @(negedge clk);
        oh = '0; oh[w] = 1'b1;
        chk("ch_resp", ch_resp, oh);
        if (!pend_wr[w]) exp_rdata = rdat;
        chk("ch_rdata", ch_rdata, exp_rdata);
        chk("resp_strobes_low", {mem_read, mem_write}, 2'b00);
        pend_vld[w] = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        ptr = (w + 1) % NUM_CH;
`endif
        won = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int won;
        int any;
        for (int i = 0; i < NUM_CH; i++) begin
            pend_vld[i] = 0; pend_wr[i] = 0; pend_both[i] = 0;
            pend_addr[i] = '0; pend_wdata[i] = '0;
        end
        apply_reqs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_ch_rdata", ch_rdata, '0);
        chk("rst_ch_resp", ch_resp, '0);
        @(posedge clk); #1 reset_n = 1'b1;

        // mem_resp in IDLE is ignored
        @(posedge clk); #1 mem_resp = 1'b1; mem_rdata = rand_line();
        @(posedge clk); #1 mem_resp = 1'b0;
        @(negedge clk);
        chk("idle_resp_ch_resp", ch_resp, '0);
        chk("idle_resp_rdata", ch_rdata, '0);
        chk("idle_resp_strobes", {mem_read, mem_write}, 2'b00);

        // Single read on ch1 at 0x40
        @(posedge clk); #1;
        set_req(1, 0, 0, 32'h0000_0040, '0); apply_reqs();
        serve(2, 0, {32{8'hA5}}, won);
        chk("single_read_winner", won, 1);
        chk("single_read_rdata", ch_rdata, {32{8'hA5}});

        // Read+write together on ch0 is a write; rdata keeps 0xA5..
        @(posedge clk); #1;
        set_req(0, 1, 1, 32'h0000_1000, {16{16'h1234}}); apply_reqs();
        serve(1, 0, rand_line(), won);
        chk("rw_winner", won, 0);
        chk("rw_rdata_kept", ch_rdata, {32{8'hA5}});

        // All channels reading back-to-back
        @(posedge clk); #1;
        for (int i = 0; i < NUM_CH; i++) set_req(i, 0, 0, $urandom, '0);
        apply_reqs();
        for (int t = 0; t < 2 * NUM_CH + 1; t++) begin
            serve($urandom_range(0, 2), 0, rand_line(), won);
            @(posedge clk); #1;
            if (won >= 0) set_req(won, 0, 0, $urandom, '0);
            apply_reqs();
        end

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            serve($urandom_range(0, 3), ($urandom_range(0, 4) == 0), rand_line(), won);
            @(posedge clk); #1;
            any = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!pend_vld[i] && $urandom_range(0, 1) == 1)
                    set_req(i, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, rand_line());
                if (pend_vld[i]) any = 1;
            end
            if (any == 0) set_req($urandom_range(0, NUM_CH - 1), 0, 0, $urandom, '0);
            apply_reqs();
        end
        // Drain so reset test starts from IDLE with known requests
        for (int t = 0; t < NUM_CH; t++) begin
            if (expected_winner() < 0) break;
            serve(0, 0, rand_line(), won);
            @(posedge clk); #1;
            apply_reqs();
        end

        // Reset during BUSY abandons the transaction
        set_req(2, 0, 0, 32'hDEAD_BEE0, '0); apply_reqs();
        won = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_read) begin won = 1; break; end
        end
        chk("rst_busy_reached", won, 1);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        chk("rst_busy_mem_read", mem_read, 0);
        chk("rst_busy_ch_resp", ch_resp, '0);
        chk("rst_busy_addr", mem_addr, '0);
        for (int i = 0; i < NUM_CH; i++) pend_vld[i] = 0;
        apply_reqs();
        ptr = 0; exp_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1 mem_resp = 1'b1; mem_rdata = rand_line();
        @(posedge clk); #1 mem_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stale_resp_ch_resp", ch_resp, '0);
            chk("stale_resp_strobes", {mem_read, mem_write}, 2'b00);
        end
        chk("stale_resp_rdata", ch_rdata, '0);
        @(posedge clk); #1;
        for (int i = 0; i < NUM_CH; i++) set_req(i, 0, 0, $urandom, '0);
        apply_reqs();
        serve(1, 0, rand_line(), won);
        chk("post_rst_winner", won, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of requesting cache channels, 2..8.
REQ-002 SHALL have parameter LINE_W, default 256: cache line width in bits.
REQ-003 SHALL have parameter ADDR_W, default 32: address width.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port ch_read, input, NUM_CH: per-channel line-read request, level, held until the matching ch_resp.
REQ-007 SHALL have port ch_write, input, NUM_CH: per-channel line-write request, level, held until the matching ch_resp.
REQ-008 SHALL have port ch_addr, input, NUM_CH*ADDR_W: packed per-channel line addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port ch_wdata, input, NUM_CH*LINE_W: packed per-channel write lines.
REQ-010 SHALL have port ch_rdata, output, LINE_W: registered read line, broadcast to all channels.
REQ-011 SHALL have port ch_resp, output, NUM_CH: one-hot completion pulse.
REQ-012 SHALL have ports mem_read and mem_write, output, 1 each: downstream (L2) request strobes.
REQ-013 SHALL have ports mem_addr (output, ADDR_W) and mem_wdata (output, LINE_W): downstream request payload.
REQ-014 SHALL have ports mem_rdata (input, LINE_W) and mem_resp (input, 1): downstream return path.

Function
REQ-015 SHALL implement the FSM states IDLE, BUSY and RESP.
REQ-016 In IDLE with any request present, SHALL select the winner as the first requesting channel at or after rr_ptr (modulo NUM_CH), latch its index, op, address and wdata, and enter BUSY.
REQ-017 In BUSY, SHALL drive the latched op, mem_addr and mem_wdata constant until mem_resp, then capture mem_rdata into ch_rdata and enter RESP.
REQ-018 In RESP, SHALL assert ch_resp[grant] for exactly one cycle, set rr_ptr = (grant+1) mod NUM_CH, and return to IDLE.
REQ-019 Latency: request in IDLE at cycle 0 -> mem strobe at cycle 1; mem_resp at cycle k -> ch_resp at cycle k+1; minimum 3 cycles per transaction.
REQ-020 SHALL not sample a request in the RESP cycle, so a requester dropping its request after ch_resp is never re-served.
REQ-021 If read and write are asserted together on one channel, SHALL treat the request as a write.
REQ-022 SHALL ignore mem_resp outside BUSY.
REQ-023 A request deasserted during BUSY SHALL NOT abort the transaction; ch_resp is still issued.
REQ-024 mem_read and mem_write SHALL never be asserted together and SHALL be 0 outside BUSY.
REQ-025 ch_rdata SHALL hold its last value until the next read completes; a write completion SHALL leave it unchanged.

Reset
REQ-026 On reset_n low, SHALL immediately force state=IDLE, rr_ptr=0, grant=0, ch_resp=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, ch_rdata=0.
REQ-027 Reset asserted mid-BUSY SHALL abandon the transaction without issuing ch_resp; a stale mem_resp after release SHALL be ignored.

Configuration
REQ-028 With MEM_ARB_FIXED_PRIO_EN defined, SHALL grant the lowest-index requesting channel (channel 0 highest, e.g. D-cache) and SHALL NOT update rr_ptr.
REQ-029 Without MEM_ARB_FIXED_PRIO_EN, SHALL use round-robin per REQ-016 and REQ-018.

Structure
REQ-030 SHALL place arb_state_t (IDLE, BUSY, RESP) in the shared rv32i_types package.
REQ-031 SHALL implement winner selection in one combinational sub-module, rr_priority_pick (inputs: req vector, pointer; outputs: one-hot grant and index).

Verification
REQ-032 NUM_CH=2 single read: ch_read[1]=1, addr 0x0000_0040 -> mem_read=1 and mem_addr=0x40 at cycle 1; mem_resp with rdata 0xA5..A5 -> ch_resp=2'b10 and ch_rdata=0xA5..A5 one cycle later.
REQ-033 NUM_CH=4 all reading continuously -> grants in order 0,1,2,3,0; each channel served once per 4 transactions.
REQ-034 Simultaneous read and write on ch0 with wdata 0x1234.. -> mem_write=1, mem_read=0, mem_wdata=0x1234..; ch_rdata unchanged.
REQ-035 reset_n pulled low while in BUSY with mem_read=1 -> mem_read=0 immediately, no ch_resp; a subsequent mem_resp is ignored; rr_ptr=0.
REQ-036 MEM_ARB_FIXED_PRIO_EN defined, ch0 and ch1 requesting continuously -> ch0 granted every transaction and ch1 starved until ch0 drops.
REQ-037 mem_resp pulsed while in IDLE -> no ch_resp and no state change.
